// File: rtl/fft_pkg.sv
// Shared constants for the 16-point R2SDF FFT pipeline.
package fft_pkg;
  localparam int WD    = 12;
  localparam int N_FFT = 16;
  localparam int NSTG  = 4;
  localparam int STAGE_DEPTH [NSTG] = '{8, 4, 2, 1};
  localparam logic signed [WD-1:0] SAT_MAX = 12'sd2047;
  localparam logic signed [WD-1:0] SAT_MIN = -12'sd2048;
endpackage

// File: rtl/butterfly.sv
// Combinational radix-2 butterfly: sat(a+b), sat(a-b) on one guard bit.
module butterfly #(
  parameter int WD = fft_pkg::WD
) (
  input  logic signed [WD-1:0] a_re,
  input  logic signed [WD-1:0] a_im,
  input  logic signed [WD-1:0] b_re,
  input  logic signed [WD-1:0] b_im,
  output logic signed [WD-1:0] sum_re,
  output logic signed [WD-1:0] sum_im,
  output logic signed [WD-1:0] diff_re,
  output logic signed [WD-1:0] diff_im
);
  // Overflow shows as disagreement between the guard bit and the result MSB.
  function automatic logic signed [WD-1:0] s_sat_13_12(input logic signed [WD:0] x);
    logic signed [WD-1:0] r;
    if (x[WD] != x[WD-1]) r = x[WD] ? {1'b1, {(WD-1){1'b0}}} : {1'b0, {(WD-1){1'b1}}};
    else                  r = x[WD-1:0];
    return r;
  endfunction

  function automatic logic signed [WD:0] sx(input logic signed [WD-1:0] v);
    return {v[WD-1], v};
  endfunction

  assign sum_re  = s_sat_13_12(sx(a_re) + sx(b_re));
  assign sum_im  = s_sat_13_12(sx(a_im) + sx(b_im));
  assign diff_re = s_sat_13_12(sx(a_re) - sx(b_re));
  assign diff_im = s_sat_13_12(sx(a_im) - sx(b_im));
endmodule

// File: rtl/r2sdf_stage.sv
// One radix-2 single-path delay-feedback stage: pairs n with n+DEPTH via a feedback delay line.
module r2sdf_stage
  import fft_pkg::*;
#(
  parameter int WD    = fft_pkg::WD,
  parameter int DEPTH = 8,
  parameter int LOGD  = 3,
  localparam int TW   = (LOGD > 0) ? LOGD : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic signed [WD-1:0] din_re,
  input  logic signed [WD-1:0] din_im,
  output logic                 out_valid,
  output logic signed [WD-1:0] dout_re,
  output logic signed [WD-1:0] dout_im,
  output logic                 dout_diff,
  output logic [TW-1:0]        tw_idx
);
  logic [LOGD:0]        cnt;
  logic                 phase, primed;
  logic [TW-1:0]        k;
  logic signed [WD-1:0] dl_re, dl_im, push_re, push_im;
  logic signed [WD-1:0] sum_re, sum_im, diff_re, diff_im;

  assign phase = cnt[LOGD];
  if (LOGD > 0) begin : g_k
    assign k = cnt[TW-1:0];
  end else begin : g_k0
    assign k = '0;
  end

  // cnt spans exactly one frame, so the natural wrap is the frame boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      primed <= 1'b0;
    end else if (in_valid) begin
      cnt <= cnt + 1'b1;
      if (phase) primed <= 1'b1;
    end
  end

  butterfly #(.WD(WD)) u_bfly (
    .a_re(dl_re), .a_im(dl_im), .b_re(din_re), .b_im(din_im),
    .sum_re(sum_re), .sum_im(sum_im), .diff_re(diff_re), .diff_im(diff_im)
  );

  // Fill phase loads fresh samples; compute phase feeds back the differences.
  assign push_re = phase ? diff_re : din_re;
  assign push_im = phase ? diff_im : din_im;

  for (genvar i = 0; i < DEPTH; i++) begin : g_dl
    logic signed [WD-1:0] re, im, nre, nim;
    if (i == 0) begin : g_head
      assign nre = push_re;
      assign nim = push_im;
    end else begin : g_tap
      assign nre = g_dl[i-1].re;
      assign nim = g_dl[i-1].im;
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        re <= '0;
        im <= '0;
      end else if (in_valid) begin
        re <= nre;
        im <= nim;
      end
    end
  end
  assign dl_re = g_dl[DEPTH-1].re;
  assign dl_im = g_dl[DEPTH-1].im;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      dout_re   <= '0;
      dout_im   <= '0;
      dout_diff <= 1'b0;
      tw_idx    <= '0;
    end else begin
      out_valid <= in_valid & (phase | primed);
      if (in_valid) begin
        dout_re   <= phase ? sum_re : dl_re;
        dout_im   <= phase ? sum_im : dl_im;
        dout_diff <= ~phase;
        tw_idx    <= k;
      end
    end
  end
endmodule
